// File: rtl/apb_requester.sv
// ============================================================================
//  Module   : apb_requester
//  Purpose  : Local valid/ready command port to APB initiator, with an
//             optional ACCESS wait-state timeout.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module apb_requester #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int              C_CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              C_TO_EN    = (TIMEOUT > 0);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_TO_EN ? C_CNT_W'(TIMEOUT - 1) : '0;

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_SETUP  = 2'd1;
    localparam logic [1:0] C_ACCESS = 2'd2;

    logic [1:0]         state_q,     state_d;
    logic [C_CNT_W-1:0] wait_cnt_q,  wait_cnt_d;
    logic [ADDR_W-1:0]  paddr_q,     paddr_d;
    logic               pwrite_q,    pwrite_d;
    logic [DATA_W-1:0]  pwdata_q,    pwdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q,   rsp_err_d;
    logic               rsp_to_q,    rsp_to_d;

    logic accept;
    logic complete;
    logic timeout_hit;

    assign accept   = cmd_valid & cmd_ready;
    assign complete = (state_q == C_ACCESS) & pready;
    // Fires on the T-th stalled ACCESS cycle; a same-cycle pready wins.
    assign timeout_hit = C_TO_EN && (state_q == C_ACCESS) && !pready
                         && (wait_cnt_q == C_CNT_LAST);

    // State register
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q     <= C_IDLE;
            wait_cnt_q  <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:   if (cmd_valid) state_d = C_SETUP;
            C_SETUP:  state_d = C_ACCESS;
            C_ACCESS: begin
                if (pready)           state_d = cmd_valid ? C_SETUP : C_IDLE;
                else if (timeout_hit) state_d = C_IDLE;
            end
            default:  state_d = C_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        psel      = 1'b0;
        penable   = 1'b0;
        cmd_ready = 1'b0;
        case (state_q)
            C_IDLE:   cmd_ready = 1'b1;
            C_SETUP:  psel      = 1'b1;
            C_ACCESS: begin
                psel      = 1'b1;
                penable   = 1'b1;
                cmd_ready = pready;
            end
            default:  cmd_ready = 1'b0;
        endcase
    end

    // Datapath: command capture, wait counter and response formation
    always_comb begin
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;

        if (accept) begin
            paddr_d    = cmd_addr;
            pwrite_d   = cmd_write;
            pwdata_d   = cmd_wdata;
            wait_cnt_d = '0;
        end else if ((state_q == C_ACCESS) && !pready) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (complete) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = pwrite_q ? '0 : prdata;
            rsp_err_d   = pslverr;
            rsp_to_d    = 1'b0;
        end else if (timeout_hit) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            rsp_to_d    = 1'b1;
        end
    end

    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;

endmodule

`default_nettype wire
